// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern scheduler.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    S_CPU,
    S_RUN,
    S_COUNT,
    S_BLINK,
    S_SWITCH
  } state_t;

  localparam logic [1:0] MODE_CPU   = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  localparam logic [7:0] RUN_INIT   = 8'h01;
  localparam logic [7:0] COUNT_INIT = 8'h00;

  function automatic state_t mode_to_state(input logic [1:0] mode);
    state_t st;
    case (mode)
      MODE_RUN:   st = S_RUN;
      MODE_COUNT: st = S_COUNT;
      MODE_BLINK: st = S_BLINK;
      default:    st = S_CPU;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mode_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for the mode switches.
module mode_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIDTH           = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_db
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any return to the accepted value restarts the stability window.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/led_ctrl_sched.sv
// LED bank scheduler: CPU pass-through or one of three timed patterns, chosen by debounced switches.
module led_ctrl_sched
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 12500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] mode_raw,
  input  logic [7:0] cpu_leds,
  output logic [1:0] mode_db,
  output logic [7:0] q
);

  localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;

  logic [1:0]    w_mode_db;
  logic          w_tick;
  logic [7:0]    w_run_next;
  state_t        r_state;
  logic [TW-1:0] r_presc;
  logic [7:0]    r_run;
  logic [7:0]    r_count;
  logic          r_phase;
  logic [7:0]    r_q;

  mode_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .WIDTH          (2)
  ) u_mode_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .i_raw  (mode_raw),
    .o_db   (w_mode_db)
  );

  assign w_tick     = (r_presc == TW'(TICK_CYCLES - 1));
  assign w_run_next = {r_run[6:0], r_run[7]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CPU;
      r_presc <= '0;
      r_run   <= RUN_INIT;
      r_count <= COUNT_INIT;
      r_phase <= 1'b0;
      r_q     <= 8'h00;
    end else if (r_state == S_SWITCH) begin
      // Target is taken from the mode at exit, so late changes need no second switch cycle.
      r_state <= mode_to_state(w_mode_db);
      r_presc <= '0;
      r_run   <= RUN_INIT;
      r_count <= COUNT_INIT;
      r_phase <= 1'b0;
      case (w_mode_db)
        MODE_CPU: r_q <= cpu_leds;
        MODE_RUN: r_q <= RUN_INIT;
        default:  r_q <= COUNT_INIT;
      endcase
    end else if (mode_to_state(w_mode_db) != r_state) begin
      // Mode change wins over a coincident tick; the tick is dropped.
      r_state <= S_SWITCH;
      r_q     <= 8'h00;
    end else begin
      if (r_state == S_CPU) begin
        r_presc <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + TW'(1);
      end
      case (r_state)
        S_RUN: begin
          if (w_tick) r_run <= w_run_next;
          r_q <= w_tick ? w_run_next : r_run;
        end
        S_COUNT: begin
          if (w_tick) r_count <= r_count + 8'd1;
          r_q <= w_tick ? r_count + 8'd1 : r_count;
        end
        S_BLINK: begin
          if (w_tick) r_phase <= ~r_phase;
          r_q <= {8{r_phase ^ w_tick}};
        end
        default: r_q <= cpu_leds;
      endcase
    end
  end

  assign mode_db = w_mode_db;
  assign q       = r_q;

endmodule

// File: tb/tb_led_ctrl_sched.sv
// Directed bench for led_ctrl_sched with short debounce and tick periods.
module tb_led_ctrl_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] mode_raw;
  logic [7:0] cpu_leds;
  logic [1:0] mode_db;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_run [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  led_ctrl_sched #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode_raw(mode_raw),
    .cpu_leds(cpu_leds),
    .mode_db (mode_db),
    .q       (q)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive a clean switch change; mode_db follows on the 6th edge, then one blank cycle.
  task automatic do_switch(input logic [1:0] m, input logic [1:0] old_m, input logic [7:0] first_q);
    mode_raw = m;
    cyc(5);
    chk2("mode_db_hold", mode_db, old_m);
    cyc(1);
    chk2("mode_db_new", mode_db, m);
    cyc(1);
    chk8("q_switch_blank", q, 8'h00);
    cyc(1);
    chk8("q_first_pattern", q, first_q);
  endtask

  initial begin
    reset_n  = 1'b0;
    mode_raw = 2'b00;
    cpu_leds = 8'h00;
    cyc(2);
    chk8("reset_q", q, 8'h00);
    chk2("reset_mode_db", mode_db, 2'b00);
    reset_n  = 1'b1;

    cpu_leds = 8'hA5;
    cyc(1);
    chk8("cpu_a5", q, 8'hA5);
    cpu_leds = 8'h3C;
    cyc(1);
    chk8("cpu_3c", q, 8'h3C);

    mode_raw = 2'b01;
    cyc(3);
    mode_raw = 2'b00;
    cyc(10);
    chk2("glitch_mode_db", mode_db, 2'b00);
    chk8("glitch_q", q, 8'h3C);

    do_switch(2'b01, 2'b00, 8'h01);
    cyc(2);
    chk8("run_hold", q, 8'h01);
    cyc(1);
    chk8("run_step", q, exp_run[0]);
    for (int i = 1; i < 8; i++) begin
      cyc(3);
      chk8("run_step", q, exp_run[i]);
    end

    do_switch(2'b11, 2'b01, 8'h00);
    cyc(3);
    chk8("blink_on", q, 8'hFF);
    cyc(3);
    chk8("blink_off", q, 8'h00);
    cyc(2);
    mode_raw = 2'b00;
    cyc(1);
    chk8("blink_on2", q, 8'hFF);
    cyc(3);
    chk8("blink_off2", q, 8'h00);
    cyc(2);
    chk2("blink_exit_mode_db", mode_db, 2'b00);
    cyc(1);
    chk8("tick_discard", q, 8'h00);
    cyc(1);
    chk8("back_to_cpu", q, 8'h3C);
    cpu_leds = 8'h5A;
    cyc(1);
    chk8("cpu_track", q, 8'h5A);

    do_switch(2'b10, 2'b00, 8'h00);
    for (int i = 1; i <= 257; i++) begin
      cyc(3);
      chk8("count_step", q, 8'(i));
    end
    cyc(123);
    chk8("count_2a", q, 8'h2A);

    #1;
    reset_n = 1'b0;
    #1;
    chk8("async_reset_q", q, 8'h00);
    chk2("async_reset_mode_db", mode_db, 2'b00);
    mode_raw = 2'b00;
    cpu_leds = 8'h77;
    #3;
    reset_n = 1'b1;
    chk8("release_q", q, 8'h00);
    cyc(1);
    chk8("post_reset_cpu", q, 8'h77);
    cyc(6);
    chk2("post_reset_mode_db", mode_db, 2'b00);
    chk8("post_reset_cpu_hold", q, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
